// File: rtl/space_invaders_pkg.sv
// Shared types and constants for the space invaders datapath blocks.
// Holds the missile scheduler FSM encoding and pool/cooldown defaults.
package space_invaders_pkg;

    typedef enum logic [1:0] {
        SCHED_IDLE,
        SCHED_GRANT_PLAYER,
        SCHED_GRANT_MONSTER
    } missile_sched_state_t;

    localparam int unsigned MISSILE_SLOTS            = 8;
    localparam int unsigned MONSTERS_DEFAULT         = 4;
    localparam int unsigned PLAYER_COOLDOWN_DEFAULT  = 15;
    localparam int unsigned MONSTER_COOLDOWN_DEFAULT = 30;

    // Bits needed to hold a frame countdown that starts at max_val.
    function automatic int unsigned cd_width(input int unsigned max_val);
        return (max_val > 0) ? $clog2(max_val + 1) : 1;
    endfunction

endpackage

// File: rtl/first_free_slot.sv
// Combinational priority encoder: one-hot select of the lowest-index slot
// that is both free and permitted by the mask.
module first_free_slot #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] busy,
    input  logic [WIDTH-1:0] mask,
    output logic [WIDTH-1:0] sel,
    output logic             found
);

    logic [WIDTH-1:0] avail;

    always_comb begin
        avail = ~busy & mask;
        sel   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (avail[i] && !found) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/missile_scheduler.sv
// Frame-synchronous launch arbiter for the shared missile slot pool.
// Define MISSILE_PLAYER_RESERVED_SLOT_EN to keep slot 0 out of monster allocation.
module missile_scheduler
    import space_invaders_pkg::*;
#(
    parameter int unsigned NUM_SLOTS        = MISSILE_SLOTS,
    parameter int unsigned NUM_MONSTERS     = MONSTERS_DEFAULT,
    parameter int unsigned PLAYER_COOLDOWN  = PLAYER_COOLDOWN_DEFAULT,
    parameter int unsigned MONSTER_COOLDOWN = MONSTER_COOLDOWN_DEFAULT
) (
    input  logic                            clk,
    input  logic                            resetN,
    input  logic                            startOfFrame,
    input  logic                            player_fire,
    input  logic [NUM_MONSTERS-1:0]         monster_fire,
    input  logic [NUM_SLOTS-1:0]            slot_release,
    output logic [NUM_SLOTS-1:0]            launch,
    output logic                            launch_is_player,
    output logic [$clog2(NUM_MONSTERS)-1:0] launch_monster,
    output logic [NUM_SLOTS-1:0]            slot_busy
);

    localparam int unsigned MW  = $clog2(NUM_MONSTERS);
    localparam int unsigned PCW = cd_width(PLAYER_COOLDOWN);
    localparam int unsigned MCW = cd_width(MONSTER_COOLDOWN);

    localparam logic [NUM_SLOTS-1:0] PLAYER_MASK = '1;
`ifdef MISSILE_PLAYER_RESERVED_SLOT_EN
    localparam logic [NUM_SLOTS-1:0] MONSTER_MASK = {{(NUM_SLOTS-1){1'b1}}, 1'b0};
`else
    localparam logic [NUM_SLOTS-1:0] MONSTER_MASK = '1;
`endif

    missile_sched_state_t state, state_next;

    logic                    player_pend;
    logic [NUM_MONSTERS-1:0] monster_pend;
    logic [NUM_MONSTERS-1:0] monster_clr;
    logic [PCW-1:0]          p_cd;
    logic [MCW-1:0]          m_cd;
    logic [MW-1:0]           rr_ptr;
    logic [MW-1:0]           rr_next;
    logic [MW-1:0]           winner;
    logic                    monster_found;

    logic [NUM_SLOTS-1:0]    search_mask;
    logic [NUM_SLOTS-1:0]    slot_sel;
    logic                    slot_found;
    logic                    player_grant;
    logic                    monster_grant;
    logic                    grant_any;
    logic                    frame_tick;

    first_free_slot #(
        .WIDTH (NUM_SLOTS)
    ) u_first_free_slot (
        .busy  (slot_busy),
        .mask  (search_mask),
        .sel   (slot_sel),
        .found (slot_found)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state <= SCHED_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next    = state;
        search_mask   = PLAYER_MASK;
        player_grant  = 1'b0;
        monster_grant = 1'b0;
        case (state)
            SCHED_IDLE: begin
                if (startOfFrame) begin
                    state_next = SCHED_GRANT_PLAYER;
                end
            end
            SCHED_GRANT_PLAYER: begin
                state_next   = SCHED_GRANT_MONSTER;
                search_mask  = PLAYER_MASK;
                player_grant = player_pend && (p_cd == '0) && slot_found;
            end
            SCHED_GRANT_MONSTER: begin
                state_next    = SCHED_IDLE;
                search_mask   = MONSTER_MASK;
                monster_grant = monster_found && (m_cd == '0) && slot_found;
            end
            default: begin
                state_next = SCHED_IDLE;
            end
        endcase
    end

    // Round-robin scan: first pending requester at or after rr_ptr, wrapping.
    always_comb begin
        int unsigned idx;
        int unsigned nxt;
        idx           = 0;
        nxt           = 0;
        winner        = '0;
        monster_found = 1'b0;
        for (int unsigned k = 0; k < NUM_MONSTERS; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM_MONSTERS) begin
                idx = idx - NUM_MONSTERS;
            end
            if (monster_pend[MW'(idx)] && !monster_found) begin
                winner        = MW'(idx);
                monster_found = 1'b1;
            end
        end
        nxt = 32'(winner) + 1;
        if (nxt >= NUM_MONSTERS) begin
            nxt = 0;
        end
        rr_next = MW'(nxt);
    end

    always_comb begin
        monster_clr = '0;
        if (monster_grant) begin
            monster_clr[winner] = 1'b1;
        end
    end

    assign grant_any  = player_grant || monster_grant;
    assign frame_tick = (state == SCHED_IDLE) && startOfFrame;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            player_pend  <= 1'b0;
            monster_pend <= '0;
            p_cd         <= '0;
            m_cd         <= '0;
            rr_ptr       <= '0;
        end else begin
            // A fresh request in the grant cycle re-arms the latch.
            player_pend  <= (player_pend && !player_grant) || player_fire;
            monster_pend <= (monster_pend & ~monster_clr) | monster_fire;

            if (player_grant) begin
                p_cd <= PCW'(PLAYER_COOLDOWN);
            end else if (frame_tick && (p_cd != '0)) begin
                p_cd <= p_cd - PCW'(1);
            end

            if (monster_grant) begin
                m_cd   <= MCW'(MONSTER_COOLDOWN);
                rr_ptr <= rr_next;
            end else if (frame_tick && (m_cd != '0)) begin
                m_cd <= m_cd - MCW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            slot_busy        <= '0;
            launch           <= '0;
            launch_is_player <= 1'b0;
            launch_monster   <= '0;
        end else begin
            // The selected slot is always free, so set and release never collide.
            slot_busy        <= (slot_busy & ~slot_release) | (slot_sel & {NUM_SLOTS{grant_any}});
            launch           <= grant_any ? slot_sel : '0;
            launch_is_player <= player_grant;
            if (monster_grant) begin
                launch_monster <= winner;
            end
        end
    end

endmodule

// File: tb/tb_missile_scheduler.sv
// Directed bench for missile_scheduler with a launch scoreboard.
// Honours MISSILE_PLAYER_RESERVED_SLOT_EN when the design is built with it.
module tb_missile_scheduler;

    localparam int unsigned NS = 8;
    localparam int unsigned NM = 4;
`ifdef MISSILE_PLAYER_RESERVED_SLOT_EN
    localparam int unsigned MBASE = 1;
`else
    localparam int unsigned MBASE = 0;
`endif

    logic          clk          = 1'b0;
    logic          resetN       = 1'b0;
    logic          startOfFrame = 1'b0;
    logic          player_fire  = 1'b0;
    logic [NM-1:0] monster_fire = '0;
    logic [NS-1:0] slot_release = '0;
    logic [NS-1:0] launch;
    logic          launch_is_player;
    logic [1:0]    launch_monster;
    logic [NS-1:0] slot_busy;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [NS-1:0] slots;
        logic          is_player;
        logic [1:0]    mon;
    } launch_t;

    launch_t sb[$];
    launch_t mon_exp;

    always #5 clk = ~clk;

    missile_scheduler #(
        .NUM_SLOTS        (NS),
        .NUM_MONSTERS     (NM),
        .PLAYER_COOLDOWN  (15),
        .MONSTER_COOLDOWN (0)
    ) dut (
        .clk              (clk),
        .resetN           (resetN),
        .startOfFrame     (startOfFrame),
        .player_fire      (player_fire),
        .monster_fire     (monster_fire),
        .slot_release     (slot_release),
        .launch           (launch),
        .launch_is_player (launch_is_player),
        .launch_monster   (launch_monster),
        .slot_busy        (slot_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Every launch pulse must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (resetN && launch != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_launch", 32'(launch), 32'h0);
            end else begin
                mon_exp = sb.pop_front();
                chk("sb_slots", 32'(launch), 32'(mon_exp.slots));
                chk("sb_is_player", 32'(launch_is_player), 32'(mon_exp.is_player));
                if (!mon_exp.is_player) begin
                    chk("sb_monster", 32'(launch_monster), 32'(mon_exp.mon));
                end
            end
        end
    end

    task automatic do_reset();
        resetN       = 1'b0;
        player_fire  = 1'b0;
        monster_fire = '0;
        slot_release = '0;
        startOfFrame = 1'b0;
        step();
        resetN = 1'b1;
        step();
    endtask

    task automatic release_slots(input logic [NS-1:0] rel);
        slot_release = rel;
        step();
        slot_release = '0;
        step();
    endtask

    task automatic frame(input bit pe, input logic [NS-1:0] ps,
                         input bit me, input logic [NS-1:0] ms, input logic [1:0] mi,
                         input logic [NS-1:0] rel);
        if (pe) sb.push_back('{slots: ps, is_player: 1'b1, mon: 2'd0});
        if (me) sb.push_back('{slots: ms, is_player: 1'b0, mon: mi});
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        slot_release = rel;
        step();
        slot_release = '0;
        chk("p_launch", 32'(launch), pe ? 32'(ps) : 32'h0);
        if (pe) chk("p_is_player", 32'(launch_is_player), 32'h1);
        step();
        chk("m_launch", 32'(launch), me ? 32'(ms) : 32'h0);
        if (me) begin
            chk("m_is_player", 32'(launch_is_player), 32'h0);
            chk("m_index", 32'(launch_monster), 32'(mi));
        end
        step();
        step();
    endtask

    // Monsters alone fill every slot they may use, one per frame.
    task automatic fill_monsters();
        monster_fire = '1;
        for (int i = 0; i < int'(NS - MBASE); i++) begin
            frame(1'b0, '0, 1'b1, NS'(1 << (i + int'(MBASE))), 2'(i % 4), '0);
        end
        monster_fire = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step();
        step();
        chk("rst_launch", 32'(launch), 32'h0);
        chk("rst_is_player", 32'(launch_is_player), 32'h0);
        chk("rst_monster", 32'(launch_monster), 32'h0);
        chk("rst_busy", 32'(slot_busy), 32'h0);
        resetN = 1'b1;
        step();

        // Single player shot.
        player_fire = 1'b1;
        step();
        player_fire = 1'b0;
        frame(1'b1, 8'h01, 1'b0, '0, 2'd0, '0);
        chk("t1_busy", 32'(slot_busy), 32'h01);

        // Reset in the grant cycle aborts the pending launch.
        do_reset();
        player_fire = 1'b1;
        step();
        player_fire  = 1'b0;
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
        #2;
        resetN = 1'b0;
        #1;
        chk("midrst_launch", 32'(launch), 32'h0);
        chk("midrst_busy", 32'(slot_busy), 32'h0);
        step();
        resetN = 1'b1;
        repeat (4) step();
        chk("midrst_launch_after", 32'(launch), 32'h0);
        chk("midrst_busy_after", 32'(slot_busy), 32'h0);

        // Held fire key: launches in frames 1, 16 and 31 only.
        do_reset();
        player_fire = 1'b1;
        for (int f = 1; f <= 40; f++) begin
            if (f == 1)       frame(1'b1, 8'h01, 1'b0, '0, 2'd0, '0);
            else if (f == 16) frame(1'b1, 8'h02, 1'b0, '0, 2'd0, '0);
            else if (f == 31) frame(1'b1, 8'h04, 1'b0, '0, 2'd0, '0);
            else              frame(1'b0, '0, 1'b0, '0, 2'd0, '0);
        end
        player_fire = 1'b0;
        chk("held_busy", 32'(slot_busy), 32'h07);

        // Round-robin over all monsters with zero cooldown.
        do_reset();
        monster_fire = '1;
        for (int f = 0; f < 5; f++) begin
            frame(1'b0, '0, 1'b1, NS'(1 << (f + int'(MBASE))), 2'(f % 4), '0);
        end
        monster_fire = '0;

        // Release and launch applied in the same cycle.
        do_reset();
        for (int m = 0; m < 3; m++) begin
            monster_fire = NM'(1 << m);
            step();
            monster_fire = '0;
            frame(1'b0, '0, 1'b1, NS'(1 << (m + int'(MBASE))), 2'(m), '0);
        end
        player_fire = 1'b1;
        step();
        player_fire = 1'b0;
        frame(1'b1, (MBASE == 1) ? 8'h01 : 8'h08, 1'b0, '0, 2'd0, 8'h04);
        chk("relaunch_busy", 32'(slot_busy), 32'h0B);

        // Only slot 0 free with monsters pending.
        do_reset();
        fill_monsters();
`ifdef MISSILE_PLAYER_RESERVED_SLOT_EN
        frame(1'b0, '0, 1'b0, '0, 2'd0, '0);
        chk("reserved_busy", 32'(slot_busy), 32'hFE);
`else
        release_slots(8'h01);
        frame(1'b0, '0, 1'b1, 8'h01, 2'd0, '0);
        chk("shared_busy", 32'(slot_busy), 32'hFF);
`endif

        // Pool full: player request waits, then takes the released slot.
        do_reset();
        fill_monsters();
`ifdef MISSILE_PLAYER_RESERVED_SLOT_EN
        player_fire = 1'b1;
        step();
        player_fire = 1'b0;
        frame(1'b1, 8'h01, 1'b0, '0, 2'd0, '0);
        for (int f = 0; f < 14; f++) begin
            frame(1'b0, '0, 1'b0, '0, 2'd0, '0);
        end
`endif
        player_fire = 1'b1;
        step();
        player_fire = 1'b0;
        frame(1'b0, '0, 1'b0, '0, 2'd0, '0);
        frame(1'b0, '0, 1'b0, '0, 2'd0, '0);
        chk("full_busy", 32'(slot_busy), 32'hFF);
        release_slots(8'h20);
        chk("full_after_release", 32'(slot_busy), 32'hDF);
        frame(1'b1, 8'h20, 1'b0, '0, 2'd0, '0);
        chk("full_refill_busy", 32'(slot_busy), 32'hFF);

        step();
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
